// File: rtl/demux_bit_scanner_if.sv
// Handshake and serial-output bundle between a scan requester and demux_bit_scanner.
interface demux_bit_scanner_if;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned SEL_W  = 3;

    logic              start;
    logic              abort;
    logic [DATA_W-1:0] data;
    logic              in_bit;
    logic [SEL_W-1:0]  sel;
    logic              step;
    logic              busy;
    logic              done;

    modport master (
        output start, abort, data,
        input  in_bit, sel, step, busy, done
    );

    modport slave (
        input  start, abort, data,
        output in_bit, sel, step, busy, done
    );
endinterface

// File: rtl/demux_bit_scanner.sv
// Serialises a captured byte onto the 1-to-8 demux data/select inputs,
// holding each channel for HOLD_CYCLES clocks, then pulses done.
module demux_bit_scanner #(
    parameter int unsigned HOLD_CYCLES = 4,
    parameter int unsigned CNT_W       = 8
) (
    input  logic               clk,
    input  logic               rst,
    demux_bit_scanner_if.slave bus
);
    localparam int unsigned DATA_W = 8;
    localparam int unsigned SEL_W  = 3;
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [SEL_W-1:0] SEL_LAST  = SEL_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic [DATA_W-1:0] shadow_q, shadow_d;
    logic              in_bit_q, in_bit_d;
    logic              step_q, step_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              accept_c;
    logic              hold_end_c;
    logic              last_chan_c;
    logic [SEL_W-1:0]  sel_nxt_c;

    assign accept_c    = bus.start & ~bus.abort;
    assign hold_end_c  = (cnt_q == HOLD_LAST);
    assign last_chan_c = (sel_q == SEL_LAST);
    assign sel_nxt_c   = sel_q + SEL_W'(1);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q    <= '0;
            sel_q    <= '0;
            shadow_q <= '0;
            in_bit_q <= 1'b0;
            step_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            sel_q    <= sel_d;
            shadow_q <= shadow_d;
            in_bit_q <= in_bit_d;
            step_q   <= step_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    // Next-state logic; abort outranks both start and channel advance
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept_c) begin
                    state_d = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (bus.abort) begin
                    state_d = ST_IDLE;
                end else if (hold_end_c && last_chan_c) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output logic: everything idles at its reset value unless a branch says otherwise
    always_comb begin
        cnt_d    = '0;
        sel_d    = '0;
        shadow_d = shadow_q;
        in_bit_d = 1'b0;
        step_d   = 1'b0;
        busy_d   = 1'b0;
        done_d   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (accept_c) begin
                    shadow_d = bus.data;
                    in_bit_d = bus.data[0];
                    step_d   = 1'b1;
                    busy_d   = 1'b1;
                end
            end
            ST_SCAN: begin
                if (bus.abort) begin
                    shadow_d = shadow_q;
                end else if (!hold_end_c) begin
                    cnt_d    = cnt_q + CNT_W'(1);
                    sel_d    = sel_q;
                    in_bit_d = in_bit_q;
                    busy_d   = 1'b1;
                end else if (!last_chan_c) begin
                    sel_d    = sel_nxt_c;
                    in_bit_d = shadow_q[sel_nxt_c];
                    step_d   = 1'b1;
                    busy_d   = 1'b1;
                end else begin
                    // Frame complete: park the select on the last channel for the done cycle
                    sel_d  = SEL_LAST;
                    done_d = 1'b1;
                end
            end
            ST_DONE: begin
                shadow_d = shadow_q;
            end
            default: begin
                shadow_d = shadow_q;
            end
        endcase
    end

    assign bus.in_bit = in_bit_q;
    assign bus.sel    = sel_q;
    assign bus.step   = step_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;

endmodule

// File: tb/tb_demux_bit_scanner.sv
// Directed bench for demux_bit_scanner: one instance at HOLD_CYCLES=4, one at HOLD_CYCLES=1.
module tb_demux_bit_scanner;
    logic clk;
    logic rst;
    int   checks;
    int   failures;

    demux_bit_scanner_if u4_if ();
    demux_bit_scanner_if u1_if ();

    demux_bit_scanner #(.HOLD_CYCLES(4), .CNT_W(8)) u_dut4 (
        .clk (clk),
        .rst (rst),
        .bus (u4_if)
    );

    demux_bit_scanner #(.HOLD_CYCLES(1), .CNT_W(8)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (u1_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic seq_a5 [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic seq_0f [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic seq_81 [8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic seq_7e [8] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic exp4(input string tag, input logic b, input logic [2:0] s,
                        input logic st, input logic bz, input logic dn);
        chk({tag, ".in_bit"}, 8'(u4_if.in_bit), 8'(b));
        chk({tag, ".sel"},    8'(u4_if.sel),    8'(s));
        chk({tag, ".step"},   8'(u4_if.step),   8'(st));
        chk({tag, ".busy"},   8'(u4_if.busy),   8'(bz));
        chk({tag, ".done"},   8'(u4_if.done),   8'(dn));
    endtask

    task automatic exp1(input string tag, input logic b, input logic [2:0] s,
                        input logic st, input logic bz, input logic dn);
        chk({tag, ".in_bit"}, 8'(u1_if.in_bit), 8'(b));
        chk({tag, ".sel"},    8'(u1_if.sel),    8'(s));
        chk({tag, ".step"},   8'(u1_if.step),   8'(st));
        chk({tag, ".busy"},   8'(u1_if.busy),   8'(bz));
        chk({tag, ".done"},   8'(u1_if.done),   8'(dn));
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        u4_if.start = 1'b0;
        u4_if.abort = 1'b0;
        u4_if.data  = 8'hA5;
        u1_if.start = 1'b0;
        u1_if.abort = 1'b0;
        u1_if.data  = 8'h00;

        // Reset held three cycles with start toggling
        for (int i = 0; i < 3; i++) begin
            tick();
            exp4("rst4", 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
            exp1("rst1", 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
            u4_if.start = ~u4_if.start;
        end

        // Normal frame A5: release reset between edges, accept on the first edge after
        rst         = 1'b0;
        u4_if.start = 1'b1;
        u4_if.data  = 8'hA5;
        #2;
        exp4("rst_release", 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
        tick();
        u4_if.start = 1'b0;
        for (int n = 0; n < 32; n++) begin
            exp4("a5_scan", seq_a5[n / 4], 3'(n / 4), (n % 4) == 0, 1'b1, 1'b0);
            tick();
        end
        exp4("a5_done", 1'b0, 3'd7, 1'b0, 1'b0, 1'b1);
        tick();
        chk("a5_idle.busy", 8'(u4_if.busy), 8'd0);
        chk("a5_idle.done", 8'(u4_if.done), 8'd0);

        // Start while busy: 0F frame, re-pulse start with F0 at sel=2 and in DONE
        u4_if.start = 1'b1;
        u4_if.data  = 8'h0F;
        tick();
        u4_if.start = 1'b0;
        for (int n = 0; n < 32; n++) begin
            exp4("0f_scan", seq_0f[n / 4], 3'(n / 4), (n % 4) == 0, 1'b1, 1'b0);
            u4_if.start = (n == 8);
            if (n == 8) u4_if.data = 8'hF0;
            tick();
        end
        exp4("0f_done", 1'b0, 3'd7, 1'b0, 1'b0, 1'b1);
        u4_if.start = 1'b1;
        tick();
        u4_if.start = 1'b0;
        for (int n = 0; n < 12; n++) begin
            exp4("0f_after", 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
            tick();
        end

        // Abort during sel=3 together with start
        u4_if.start = 1'b1;
        u4_if.data  = 8'hFF;
        tick();
        u4_if.start = 1'b0;
        for (int n = 0; n < 14; n++) begin
            exp4("ff_scan", 1'b1, 3'(n / 4), (n % 4) == 0, 1'b1, 1'b0);
            if (n != 13) tick();
        end
        u4_if.abort = 1'b1;
        u4_if.start = 1'b1;
        tick();
        u4_if.abort = 1'b0;
        u4_if.start = 1'b0;
        exp4("abort_now", 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
        for (int n = 0; n < 36; n++) begin
            tick();
            chk("abort_after.busy", 8'(u4_if.busy), 8'd0);
            chk("abort_after.done", 8'(u4_if.done), 8'd0);
        end

        // Asynchronous reset pulse during sel=5
        u4_if.start = 1'b1;
        u4_if.data  = 8'h20;
        tick();
        u4_if.start = 1'b0;
        repeat (20) tick();
        exp4("ar_sel5", 1'b1, 3'd5, 1'b1, 1'b1, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        exp4("ar_mid", 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
        #1;
        rst = 1'b0;
        u4_if.start = 1'b1;
        u4_if.data  = 8'h01;
        tick();
        u4_if.start = 1'b0;
        exp4("ar_restart", 1'b1, 3'd0, 1'b1, 1'b1, 1'b0);
        tick();
        exp4("ar_hold", 1'b1, 3'd0, 1'b0, 1'b1, 1'b0);
        repeat (31) tick();
        exp4("ar_done", 1'b0, 3'd7, 1'b0, 1'b0, 1'b1);
        tick();

        // Back-to-back frames at H=1 with start held high
        u1_if.start = 1'b1;
        u1_if.data  = 8'h81;
        tick();
        u1_if.data  = 8'h7E;
        for (int k = 0; k < 8; k++) begin
            exp1("b81_scan", seq_81[k], 3'(k), 1'b1, 1'b1, 1'b0);
            tick();
        end
        exp1("b81_done", 1'b0, 3'd7, 1'b0, 1'b0, 1'b1);
        tick();
        exp1("b81_idle", 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
        tick();
        for (int k = 0; k < 8; k++) begin
            exp1("b7e_scan", seq_7e[k], 3'(k), 1'b1, 1'b1, 1'b0);
            tick();
        end
        u1_if.start = 1'b0;
        exp1("b7e_done", 1'b0, 3'd7, 1'b0, 1'b0, 1'b1);
        tick();
        exp1("b7e_idle", 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
        tick();
        exp1("b7e_quiet", 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/demux_bit_scanner.md
# demux_bit_scanner

Serialises an 8-bit word onto the data and select inputs of the 1-to-8 demultiplexer stage. The word is presented one bit per channel, with each bit held for a programmable number of clock cycles so it is visible on the lab board. The block sits directly upstream of the demultiplexer: `in_bit` drives its data input and `sel` drives its 3-bit select. After a start request it steps channels 0 to 7 in order, then signals completion.

## Interface

Parameters:
- `HOLD_CYCLES`, default 4: clock cycles each channel is held. Legal values are 1 and above.
- `CNT_W`, default 8: width of the hold counter. It must hold the value `HOLD_CYCLES-1`.

Ports (name, direction, width, meaning):
- `clk` in 1: the single clock. All state changes on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: request to scan `data`. Sampled only in IDLE.
- `abort` in 1: synchronous cancel of the scan in progress.
- `data` in 8: word to serialise. Captured on the accepting edge.
- `in_bit` out 1: serial bit, feeding the demultiplexer data input.
- `sel` out 3: channel index, feeding the demultiplexer select.
- `step` out 1: one-cycle pulse in the first cycle of each channel.
- `busy` out 1: high while scanning (SCAN state).
- `done` out 1: one-cycle pulse when a frame completes normally.

## Operation

- States: IDLE, SCAN, DONE. Reset enters IDLE.
- Reset values: `in_bit`=0, `sel`=0, `step`=0, `busy`=0, `done`=0, hold counter 0, shadow register 0.
- IDLE, with `start`=1 and `abort`=0 on an edge:
  - `data` is copied to the shadow register.
  - Next state SCAN, with `sel`=0, `in_bit`=`data[0]`, counter 0, `step`=1.
- SCAN, each edge:
  - If the counter is below `HOLD_CYCLES-1`, the counter increments; `step`=0.
  - If the counter equals `HOLD_CYCLES-1` and `sel`<7: `sel` increments, `in_bit`=`shadow[sel+1]`, counter clears, `step`=1.
  - If the counter equals `HOLD_CYCLES-1` and `sel`=7: next state DONE.
- DONE lasts exactly one cycle, then returns to IDLE.
  - Outputs in DONE: `done`=1, `busy`=0, `in_bit`=0, `sel` holds 7.
- `abort`=1 on any edge in SCAN or DONE: next state IDLE with reset output values. No `done` pulse is produced.
- Simultaneous events:
  - `abort` beats channel advance.
  - `abort` beats `start`.
- `start` is ignored in SCAN and DONE. It is not queued.
- `data` changes after the accepting edge have no effect on the frame in progress.
- `sel` never exceeds 7. The select value does not wrap during a frame.
- Reset asserted mid-frame clears all state immediately, without waiting for a clock edge.

## Timing

- Let E0 be the edge that accepts `start`. Edges are numbered from E0 with spacing H = `HOLD_CYCLES`.
- `sel`=k for the H cycles that follow edge E0+k·H, for k = 0..7.
- `step` is high in the first of those H cycles.
- `busy` is high for exactly 8·H cycles.
- The edge at E0+8·H enters DONE, so `done` is high in the following cycle.
- The edge at E0+8·H+1 returns to IDLE. The earliest next accepting edge is E0+8·H+2, giving a frame period of 8·H+2 cycles.
- With H=1, every cycle of the scan advances the channel: 8 `step` pulses in 8 consecutive cycles.
- There is no combinational path from inputs to outputs. All outputs are registered.

## Test plan

- Reset: hold `rst`=1 for 3 cycles with `start`=1 toggling.
  - Required: `in_bit`, `sel`, `step`, `busy`, `done` all 0.
  - Required: no scan starts until the first edge after `rst` falls.
- Normal frame: H=4, `data`=8'hA5, single-cycle `start`.
  - Required `sel` sequence 0..7, each value held 4 cycles.
  - Required `in_bit` sequence 1,0,1,0,0,1,0,1.
  - Required: 8 `step` pulses, `busy` high for 32 cycles, `done` pulse in cycle 33 after E0.
- Start while busy: H=4, `data`=8'h0F, then re-pulse `start` with `data`=8'hF0 at sel=2 and again in the DONE cycle.
  - Required: the frame completes with the 8'h0F pattern.
  - Required: exactly one `done` pulse and no second frame.
- Abort: H=4, `data`=8'hFF, assert `abort` during sel=3, together with `start`.
  - Required: the next cycle shows IDLE with all outputs 0.
  - Required: no `done` pulse.
  - Required: the simultaneous `start` is not accepted.
- Asynchronous reset mid-frame: during sel=5, pulse `rst` between clock edges.
  - Required: outputs go to 0 before the next edge.
  - Required: a fresh `start` afterwards scans from sel=0.
- Back-to-back frames: H=1, `start` held high, `data`=8'h81 then 8'h7E.
  - Required: frames accepted at E0 and E0+10.
  - Required `in_bit` patterns 1,0,0,0,0,0,0,1 and then 0,1,1,1,1,1,1,0.
  - Required: a `done` pulse after each frame.
